// File: rtl/score_argmax.sv
// Argmax over the ten FC-layer class scores. It captures the score vector when the FC
// layer signals done, scans one score per cycle, and holds the winner for display.
module score_argmax #(
  parameter int BIT     = 16,
  parameter int N_CLASS = 10
) (
  input  logic                   clk,
  input  logic                   iRst_n,
  input  logic                   ena,
  input  logic                   start,
  input  logic [N_CLASS*BIT-1:0] scores,
  input  logic                   overflow_in,
  output logic                   busy,
  output logic                   done,
  output logic [3:0]             class_idx,
  output logic [BIT-1:0]         max_score,
  output logic [N_CLASS-1:0]     onehot,
  output logic                   overflow
);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [3:0] LAST = 4'(N_CLASS - 1);

  state_t                         state;
  logic [N_CLASS-1:0][BIT-1:0]    snap;
  logic [3:0]                     cnt;

  // Sign-magnitude "a > b"; +0 and -0 compare equal.
  function automatic logic gt(input logic [BIT-1:0] a, input logic [BIT-1:0] b);
    logic [BIT-2:0] ma, mb;
    ma = a[BIT-2:0];
    mb = b[BIT-2:0];
    if (ma == '0 && mb == '0)        gt = 1'b0;
    else if (!a[BIT-1] && b[BIT-1])  gt = 1'b1;
    else if (a[BIT-1] && !b[BIT-1])  gt = 1'b0;
    else if (!a[BIT-1])              gt = (ma > mb);
    else                             gt = (ma < mb);
  endfunction

  logic [BIT-1:0] cur;
  logic           win;
  logic [3:0]     nxt_idx;
  logic [BIT-1:0] nxt_max;

  always_comb begin
    cur     = snap[cnt];
    win     = gt(cur, max_score);
    nxt_idx = win ? cnt : class_idx;
    nxt_max = win ? cur : max_score;
  end

  always_ff @(posedge clk) begin
    if (!iRst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      class_idx <= '0;
      max_score <= '0;
      onehot    <= '0;
      snap      <= '0;
      cnt       <= '0;
    end else if (ena) begin
      case (state)
        IDLE: begin
          if (start) begin
            snap      <= scores;
            max_score <= scores[BIT-1:0];
            class_idx <= '0;
            cnt       <= 4'd1;
            busy      <= 1'b1;
            overflow  <= overflow_in;
            state     <= SCAN;
          end
        end
        SCAN: begin
          max_score <= nxt_max;
          class_idx <= nxt_idx;
          cnt       <= cnt + 4'd1;
          if (cnt == LAST) begin
            busy   <= 1'b0;
            done   <= 1'b1;
            onehot <= N_CLASS'(1) << nxt_idx;
            state  <= DONE;
          end
        end
        DONE: begin
          // Start is a level held by the FC layer; only its drop re-arms the block.
          if (!start) begin
            done   <= 1'b0;
            onehot <= '0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_score_argmax.sv
// Directed-vector bench for score_argmax with hand-computed expected results.
module tb_score_argmax;
  localparam int BIT = 16;
  localparam int N   = 10;

  logic             clk = 1'b0;
  logic             iRst_n, ena, start, overflow_in;
  logic [N*BIT-1:0] scores;
  logic             busy, done, overflow;
  logic [3:0]       class_idx;
  logic [BIT-1:0]   max_score;
  logic [N-1:0]     onehot;

  int tests = 0;
  int fails = 0;

  score_argmax #(.BIT(BIT), .N_CLASS(N)) dut (
    .clk(clk), .iRst_n(iRst_n), .ena(ena), .start(start), .scores(scores),
    .overflow_in(overflow_in), .busy(busy), .done(done), .class_idx(class_idx),
    .max_score(max_score), .onehot(onehot), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [15:0] v);
    for (int i = 0; i < N; i++) scores[BIT*i +: BIT] = v;
  endtask

  task automatic test_reset();
    iRst_n = 1'b0; ena = 1'b1; start = 1'b0; overflow_in = 1'b0; fill(16'h0000);
    step();
    tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (done !== 1'b0)      begin fails++; $display("FAIL reset_done got %b want 0", done); end
    tests++; if (class_idx !== 4'd0) begin fails++; $display("FAIL reset_idx got %0d want 0", class_idx); end
    tests++; if (max_score !== 16'h0) begin fails++; $display("FAIL reset_max got %h want 0", max_score); end
    tests++; if (onehot !== 10'b0)   begin fails++; $display("FAIL reset_onehot got %b want 0", onehot); end
    tests++; if (overflow !== 1'b0)  begin fails++; $display("FAIL reset_ovf got %b want 0", overflow); end
    iRst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    fill(16'h3800);
    scores[7*BIT +: BIT] = 16'h4000;
    scores[8*BIT +: BIT] = 16'h3C00;
    scores[9*BIT +: BIT] = 16'h3C00;
    start = 1'b1;
    step();
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy_capture got %b want 1", busy); end
    for (int i = 0; i < 8; i++) step();
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL basic_done_early got %b want 0", done); end
    step();
    tests++; if (done !== 1'b1)      begin fails++; $display("FAIL basic_done got %b want 1", done); end
    tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL basic_busy got %b want 0", busy); end
    tests++; if (class_idx !== 4'd7) begin fails++; $display("FAIL basic_idx got %0d want 7", class_idx); end
    tests++; if (max_score !== 16'h4000) begin fails++; $display("FAIL basic_max got %h want 4000", max_score); end
    tests++; if (onehot !== 10'b0010000000) begin fails++; $display("FAIL basic_onehot got %b want 0010000000", onehot); end
    tests++; if (overflow !== 1'b0)  begin fails++; $display("FAIL basic_ovf got %b want 0", overflow); end
    start = 1'b0;
    step();
    tests++; if (done !== 1'b0 || onehot !== 10'b0) begin fails++; $display("FAIL basic_release got done=%b onehot=%b want 0/0", done, onehot); end
    tests++; if (class_idx !== 4'd7) begin fails++; $display("FAIL basic_idx_kept got %0d want 7", class_idx); end
  endtask

  task automatic test_negative();
    fill(16'hBC00);
    scores[4*BIT +: BIT] = 16'hB800;
    start = 1'b1;
    for (int i = 0; i < 10; i++) step();
    tests++; if (done !== 1'b1 || class_idx !== 4'd4) begin fails++; $display("FAIL neg_idx got done=%b idx=%0d want 1/4", done, class_idx); end
    tests++; if (max_score !== 16'hB800) begin fails++; $display("FAIL neg_max got %h want b800", max_score); end
    tests++; if (onehot !== 10'b0000010000) begin fails++; $display("FAIL neg_onehot got %b want 0000010000", onehot); end
    start = 1'b0;
    step();
  endtask

  task automatic test_ties();
    fill(16'h3C00);
    scores[2*BIT +: BIT] = 16'h4000;
    scores[6*BIT +: BIT] = 16'h4000;
    start = 1'b1;
    for (int i = 0; i < 10; i++) step();
    tests++; if (class_idx !== 4'd2 || max_score !== 16'h4000) begin fails++; $display("FAIL tie_idx got idx=%0d max=%h want 2/4000", class_idx, max_score); end
    start = 1'b0;
    step();
    fill(16'hBC00);
    scores[0*BIT +: BIT] = 16'h8000;
    scores[3*BIT +: BIT] = 16'h0000;
    start = 1'b1;
    for (int i = 0; i < 10; i++) step();
    tests++; if (class_idx !== 4'd0 || max_score !== 16'h8000) begin fails++; $display("FAIL zero_idx got idx=%0d max=%h want 0/8000", class_idx, max_score); end
    tests++; if (onehot !== 10'b0000000001) begin fails++; $display("FAIL zero_onehot got %b want 0000000001", onehot); end
    start = 1'b0;
    step();
  endtask

  task automatic test_ena_stall();
    fill(16'h3800);
    scores[7*BIT +: BIT] = 16'h4000;
    overflow_in = 1'b1;
    start = 1'b1;
    step();
    overflow_in = 1'b0;
    fill(16'h1000);
    scores[9*BIT +: BIT] = 16'h7C00;
    step(); step();
    ena = 1'b0;
    step(); step(); step();
    tests++; if (busy !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL stall_hold got busy=%b done=%b want 1/0", busy, done); end
    ena = 1'b1;
    for (int i = 0; i < 6; i++) step();
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL stall_done_early got %b want 0", done); end
    step();
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL stall_done got %b want 1", done); end
    tests++; if (class_idx !== 4'd7 || max_score !== 16'h4000) begin fails++; $display("FAIL stall_result got idx=%0d max=%h want 7/4000", class_idx, max_score); end
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL stall_ovf got %b want 1", overflow); end
    start = 1'b0;
    step();
  endtask

  task automatic test_reset_midscan();
    fill(16'hBC00);
    scores[4*BIT +: BIT] = 16'hB800;
    start = 1'b1;
    for (int i = 0; i < 6; i++) step();
    iRst_n = 1'b0;
    step();
    tests++; if (busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b0) begin fails++; $display("FAIL mid_rst_flags got busy=%b done=%b ovf=%b want 0/0/0", busy, done, overflow); end
    tests++; if (class_idx !== 4'd0 || max_score !== 16'h0 || onehot !== 10'b0) begin fails++; $display("FAIL mid_rst_data got idx=%0d max=%h onehot=%b want 0/0/0", class_idx, max_score, onehot); end
    iRst_n = 1'b1;
    for (int i = 0; i < 9; i++) step();
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL mid_rst_done_early got %b want 0", done); end
    step();
    tests++; if (done !== 1'b1 || class_idx !== 4'd4) begin fails++; $display("FAIL mid_rst_rescan got done=%b idx=%0d want 1/4", done, class_idx); end
  endtask

  task automatic test_back_to_back();
    // Still in DONE with start high from the previous scan: must not rescan.
    fill(16'h3C00);
    scores[1*BIT +: BIT] = 16'h5000;
    for (int i = 0; i < 12; i++) step();
    tests++; if (done !== 1'b1 || class_idx !== 4'd4 || max_score !== 16'hB800) begin fails++; $display("FAIL b2b_hold got done=%b idx=%0d max=%h want 1/4/b800", done, class_idx, max_score); end
    start = 1'b0;
    step();
    tests++; if (done !== 1'b0 || onehot !== 10'b0 || class_idx !== 4'd4) begin fails++; $display("FAIL b2b_release got done=%b onehot=%b idx=%0d want 0/0/4", done, onehot, class_idx); end
    start = 1'b1;
    for (int i = 0; i < 10; i++) step();
    tests++; if (done !== 1'b1 || class_idx !== 4'd1 || max_score !== 16'h5000) begin fails++; $display("FAIL b2b_new got done=%b idx=%0d max=%h want 1/1/5000", done, class_idx, max_score); end
    tests++; if (onehot !== 10'b0000000010) begin fails++; $display("FAIL b2b_onehot got %b want 0000000010", onehot); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_ties();
    test_ena_stall();
    test_reset_midscan();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/score_argmax.md
# score_argmax

Reads the ten class scores that the second fully-connected layer writes as its output vector and finds the index of the largest score. It starts when that layer's `done` output goes high and compares the scores one per cycle. It then holds the winning class index, its score, a one-hot display vector and the overflow status stable for the display logic.

## Interface
Parameters:
- `BIT`, 16: width of one score (sign-magnitude half float: sign, exponent, mantissa).
- `N_CLASS`, 10: number of scores; index width fixed at 4 bits.

Ports:
- `clk` in 1: clock.
- `iRst_n` in 1: reset, synchronous, active-low; has priority over `ena`.
- `ena` in 1: block enable. Low means every register holds its value.
- `start` in 1: connected to the FC layer's `done`. Level-sensitive; the FC layer holds it high until its own reset.
- `scores` in N_CLASS*BIT: FC output vector. Score i is at bits [BIT*i+BIT-1 : BIT*i].
- `overflow_in` in 1: the FC layer's overflow flag.
- `busy` out 1: high while a scan is in progress.
- `done` out 1: result valid.
- `class_idx` out 4: index of the maximum score.
- `max_score` out BIT: value of the maximum score.
- `onehot` out N_CLASS: bit `class_idx` set when `done`, otherwise all zero.
- `overflow` out 1: the `overflow_in` value captured at the snapshot.

## Operation
- Reset values:
  - state = IDLE.
  - `busy`, `done`, `overflow` = 0.
  - `class_idx` = 0, `max_score` = 0, `onehot` = 0.
  - Snapshot register and scan counter = 0.
- States:
  - **IDLE**: if `start` = 1, do all of the following on the same edge, then go to SCAN:
    - copy `scores` into the internal snapshot register;
    - set `max_score` = score 0, `class_idx` = 0, scan counter = 1;
    - set `busy` = 1;
    - set `overflow` = `overflow_in`.
  - **SCAN**: each cycle compare snapshot score[counter] with `max_score`.
    - If strictly greater, replace `max_score` and `class_idx`. Then counter += 1.
    - On the edge that compares index N_CLASS-1: `busy` = 0, `done` = 1, `onehot` = 1 << winning index (the index after this comparison), go to DONE.
  - **DONE**: hold all outputs.
    - `start` = 0: go to IDLE, clear `done` and `onehot`; `class_idx`, `max_score` and `overflow` keep their values.
    - `start` = 1: stay in DONE; no rescan.
  - Unreachable state encodings go to IDLE.
- Comparison rule (a > b), sign-magnitude, where mag = low BIT-1 bits:
  - Both magnitudes 0: equal (+0 == -0).
  - a positive, b negative: a > b, unless both are zero.
  - Both positive: a > b when mag_a > mag_b.
  - Both negative: a > b when mag_a < mag_b.
  - Ties keep the earlier (lower) index.
- Scores are compared only from the snapshot. Changes on `scores` after capture are ignored.
- `overflow_in` = 1 does not suppress the scan; the result is still produced, with `overflow` = 1.

## Timing
- Edge 0: `start` is sampled high in IDLE. The snapshot is taken and `busy` = 1.
- Edges 1 to 9: the comparisons for indices 1 to 9.
- `done` = 1 and `onehot` are valid after edge 9, i.e. N_CLASS-1 edges after capture.
- `start` low for one cycle in DONE leads to IDLE. A new scan needs `start` high again (at least one cycle later).
- `ena` low at any point freezes the state, counter and outputs; the scan resumes where it stopped when `ena` returns high. Total latency stretches by the number of cycles `ena` was low.
- `iRst_n` low mid-scan: next edge gives the reset values, the scan is abandoned and `start` must be sampled again.
- Reset and `ena` low together: the reset is applied.

## Test plan
- Scores {0x3800 ×7, 0x4000 at idx 7, 0x3C00 ×2}, `start` high -> after 10 cycles `done` = 1, `class_idx` = 7, `max_score` = 0x4000, `onehot` = 10'b0010000000, `busy` low.
- All negative: idx 0–9 = 0xBC00 except idx 4 = 0xB800 -> `class_idx` = 4, `max_score` = 0xB800.
- Ties and signed zero:
  - idx 2 = idx 6 = 0x4000, others 0x3C00 -> `class_idx` = 2.
  - idx 0 = 0x8000, idx 3 = 0x0000, others negative -> `class_idx` = 0.
- `ena` low for 3 cycles during SCAN and `scores` changed after capture -> `done` appears 3 cycles late and the result matches the captured vector; `overflow_in` = 1 at capture gives `overflow` = 1.
- `iRst_n` low at scan cycle 5 -> all outputs at reset values the next cycle. With `start` still high, a fresh scan completes 10 cycles after reset is released.
- In DONE, `start` drops -> `done` = 0 and `onehot` = 0 while `class_idx` is retained; raise `start` again with a new vector -> a new result.
